// File: rtl/hc_keystream_xor.sv
// hc_keystream_xor
//   Consumer side of the hc_core keystream interface. Requests keystream words
//   from the core one at a time (never more than one outstanding), buffers them
//   in a small prefetch FIFO and XORs them, in order, onto a ready/valid data
//   stream. Encryption and decryption are the same operation.
//
// Parameters
//   FIFO_DEPTH  prefetch FIFO depth in words (power of two, >= 2)
//   ADDR_W      log2(FIFO_DEPTH)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                1 = keep prefetching keystream
//   flush                 1-cycle pulse: drop buffered/in-flight keystream, clear error
//   ks_next               1-cycle request pulse to the core
//   ks_data, ks_valid     keystream word returned by the core
//   din, din_valid/ready  input data stream
//   dout, dout_valid/ready output data stream (din XOR keystream, 1-cycle latency)
//   error                 sticky: keystream word arrived with no request outstanding
//   word_cnt              64-bit count of delivered output words
//
// Configuration macro
//   HC_WORD_CNT_EN        when defined, adds the word_cnt port and its counter

module hc_keystream_xor #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        flush,
  output logic        ks_next,
  input  logic [31:0] ks_data,
  input  logic        ks_valid,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        error
`ifdef HC_WORD_CNT_EN
  ,
  output logic [63:0] word_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic                ks_next_q, ks_next_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [31:0]         dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                error_q, error_d;

  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                push_s;
  logic                err_set_s;
  logic                din_xfer_s;
  logic                dout_xfer_s;

  assign fifo_empty_s = (fill_q == {(ADDR_W + 1){1'b0}});
  assign fifo_full_s  = (fill_q == DEPTH_L);
  assign din_ready    = !fifo_empty_s && (!dout_valid_q || dout_ready);
  // flush wins over a same-cycle input transfer
  assign din_xfer_s   = din_valid && din_ready && !flush;
  assign dout_xfer_s  = dout_valid_q && dout_ready;

  // Request FSM: next state, request pulse, push and unsolicited-word detection
  always_comb begin
    state_d   = state_q;
    ks_next_d = 1'b0;
    push_s    = 1'b0;
    err_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          err_set_s = ks_valid;
          if (enable && !fifo_full_s) begin
            ks_next_d = 1'b1;
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          // a word arriving in the flush cycle is simply dropped
          state_d = ks_valid ? ST_IDLE : ST_DRAIN;
        end else if (ks_valid) begin
          push_s  = !fifo_full_s;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // another flush here must still wait for the in-flight word
        if (ks_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointers and fill level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = {ADDR_W{1'b0}};
      rd_ptr_d = {ADDR_W{1'b0}};
      fill_d   = {(ADDR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (din_xfer_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, din_xfer_s})
        2'b10:   fill_d = fill_q + (ADDR_W + 1)'(1);
        2'b01:   fill_d = fill_q - (ADDR_W + 1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // XOR output stage and sticky error
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    error_d      = error_q;
    if (flush) begin
      dout_valid_d = 1'b0;
      error_d      = 1'b0;
    end else begin
      if (din_xfer_s) begin
        dout_d       = din ^ mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end else if (dout_xfer_s) begin
        dout_valid_d = 1'b0;
      end else begin
        dout_valid_d = dout_valid_q;
      end
      if (err_set_s) begin
        error_d = 1'b1;
      end else begin
        error_d = error_q;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ks_next_q    <= 1'b0;
      wr_ptr_q     <= {ADDR_W{1'b0}};
      rd_ptr_q     <= {ADDR_W{1'b0}};
      fill_q       <= {(ADDR_W + 1){1'b0}};
      dout_q       <= 32'd0;
      dout_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ks_next_q    <= ks_next_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      error_q      <= error_d;
    end
  end

  // FIFO storage; contents are only meaningful below the fill level
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= ks_data;
    end
  end

  assign ks_next    = ks_next_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign error      = error_q;

`ifdef HC_WORD_CNT_EN
  logic [63:0] word_cnt_q;

  // Delivered-word counter; survives flush, wraps naturally at 2^64
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_q <= 64'd0;
    end else if (dout_xfer_s) begin
      word_cnt_q <= word_cnt_q + 64'd1;
    end else begin
      word_cnt_q <= word_cnt_q;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_hc_keystream_xor.sv
module tb_hc_keystream_xor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        ks_next;
  logic [31:0] ks_data = 32'd0;
  logic        ks_valid = 1'b0;
  logic [31:0] din = 32'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        error;
`ifdef HC_WORD_CNT_EN
  logic [63:0] word_cnt;
`endif

  hc_keystream_xor #(.FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .flush      (flush),
    .ks_next    (ks_next),
    .ks_data    (ks_data),
    .ks_valid   (ks_valid),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .error      (error)
`ifdef HC_WORD_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus knobs applied by the next cycle
  bit          en_i, fl_i, dv_i, rdy_i, inj_i;
  logic [31:0] dval_i;
  int          lat = 3;
  bit          directed = 1'b1;
  logic [31:0] dk = 32'd0;

  // reference model: words the core handed over and not yet consumed, output
  // words in flight, requests outstanding at the core (and whether flushed)
  logic [31:0] exp_ks [$];
  logic [31:0] exp_out [$];
  int          due [$];
  bit          stale [$];
  logic [31:0] outs [$];
  logic [31:0] m_dout;
  bit          m_err;
  logic [63:0] m_cnt;
  int          cyc = 0;
  int          n_req = 0;
  int          n_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic cycle();
    bit deliver, unsol, in_x, out_x;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    enable     = en_i;
    flush      = fl_i;
    din_valid  = dv_i;
    din        = dval_i;
    dout_ready = rdy_i;
    deliver  = (due.size() != 0) && (due[0] == cyc);
    unsol    = 1'b0;
    ks_valid = 1'b0;
    ks_data  = $urandom;
    if (deliver) begin
      ks_valid = 1'b1;
      if (directed) begin
        dk = dk + 32'h11111111;
        ks_data = dk;
      end
    end else if (inj_i && due.size() == 0 && !ks_next) begin
      ks_valid = 1'b1;
      unsol = 1'b1;
    end
    #1;
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, exp_out.size() != 0);
    chk("din_ready", din_ready, (exp_ks.size() != 0) && (exp_out.size() == 0 || dout_ready));
    chk("error", error, m_err);
`ifdef HC_WORD_CNT_EN
    chk("word_cnt", word_cnt, m_cnt);
`endif
    if (ks_next) begin
      n_req++;
      chk("one_outstanding", due.size(), 0);
      chk("req_not_full", exp_ks.size() < 4, 1);
      due.push_back(cyc + lat);
      stale.push_back(1'b0);
    end
    out_x = dout_valid && dout_ready;
    in_x  = din_valid && din_ready && !fl_i;
    if (out_x) begin
      outs.push_back(dout);
      if (exp_out.size() != 0) void'(exp_out.pop_front());
      m_cnt = m_cnt + 64'd1;
    end
    if (fl_i) begin
      exp_ks.delete();
      exp_out.delete();
      m_err = 1'b0;
      foreach (stale[i]) stale[i] = 1'b1;
    end else if (in_x) begin
      w = (exp_ks.size() != 0) ? exp_ks.pop_front() : 32'd0;
      m_dout = din ^ w;
      exp_out.push_back(m_dout);
      n_acc++;
    end
    if (deliver) begin
      if (!stale[0]) exp_ks.push_back(ks_data);
      void'(due.pop_front());
      void'(stale.pop_front());
    end
    if (unsol && !fl_i) m_err = 1'b1;
  endtask

  task automatic idle_knobs();
    en_i = 1'b0; fl_i = 1'b0; dv_i = 1'b0; rdy_i = 1'b1; inj_i = 1'b0; dval_i = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ks_next", ks_next, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_error", error, 0);
`ifdef HC_WORD_CNT_EN
    chk("rst_word_cnt", word_cnt, 0);
`endif
    idle_knobs();
    enable = 1'b0; flush = 1'b0; din_valid = 1'b0; ks_valid = 1'b0;
    exp_ks.delete(); exp_out.delete(); due.delete(); stale.delete(); outs.delete();
    m_dout = 32'd0; m_err = 1'b0; m_cnt = 64'd0; n_req = 0; n_acc = 0; dk = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] w);
    int a0;
    a0 = n_acc;
    dv_i = 1'b1; dval_i = w;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (n_acc != a0) break;
    end
    dv_i = 1'b0;
    chk("send_accepted", n_acc - a0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, fill0, base;
    logic [31:0] dk_flush;
    idle_knobs();
    do_reset();

    // basic XOR with counting keystream, latency 3
    directed = 1'b1; lat = 3; en_i = 1'b1;
    repeat (12) cycle();
    send(32'hA5A5A5A5);
    send(32'h0F0F0F0F);
    repeat (4) cycle();
    chk("xor_count", outs.size(), 2);
    if (outs.size() >= 2) begin
      chk("xor_word0", outs[0], 32'hB4B4B4B4);
      chk("xor_word1", outs[1], 32'h2D2D2D2D);
    end

    // prefetch fill: exactly FIFO_DEPTH requests, then none
    do_reset();
    en_i = 1'b1;
    repeat (40) cycle();
    chk("prefetch_reqs", n_req, 4);
    chk("prefetch_din_ready", din_ready, 1);

    // backpressure: one word accepted while dout_ready is low
    rdy_i = 1'b0; dv_i = 1'b1; dval_i = $urandom;
    a0 = n_acc;
    repeat (10) cycle();
    chk("bp_one_accept", n_acc - a0, 1);
    rdy_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dval_i = $urandom;
      cycle();
    end
    dv_i = 1'b0;
    chk("bp_resumed", n_acc - a0 > 5, 1);

    // flush while a request is in flight
    repeat (30) cycle();
    dv_i = 1'b1; dval_i = 32'd0;
    repeat (3) cycle();
    dv_i = 1'b0;
    lat = 4;
    r0 = n_req;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (n_req != r0) break;
    end
    chk("flush_req_seen", n_req - r0, 1);
    dk_flush = dk;
    fl_i = 1'b1; cycle(); fl_i = 1'b0;
    repeat (8) cycle();
    chk("flush_error", error, 0);
    base = outs.size();
    send(32'd0);
    cycle();
    chk("flush_out", outs.size() - base, 1);
    if (outs.size() > base) chk("flush_fresh_word", outs[base], dk_flush + 32'h22222222);

    // unsolicited keystream word
    en_i = 1'b0;
    repeat (20) cycle();
    fill0 = exp_ks.size();
    inj_i = 1'b1; cycle(); inj_i = 1'b0;
    cycle();
    chk("unsol_error", error, 1);
    a0 = n_acc;
    dv_i = 1'b1;
    repeat (20) cycle();
    dv_i = 1'b0;
    chk("unsol_fill", n_acc - a0, fill0);
    fl_i = 1'b1; cycle(); fl_i = 1'b0;
    cycle();
    chk("unsol_cleared", error, 0);

    // randomized traffic against the model
    directed = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      en_i   = ($urandom % 8) != 0;
      fl_i   = ($urandom % 40) == 0;
      inj_i  = ($urandom % 60) == 0;
      dv_i   = $urandom % 2;
      rdy_i  = ($urandom % 4) != 0;
      dval_i = $urandom;
      lat    = $urandom_range(1, 5);
      cycle();
    end
    idle_knobs();
    repeat (10) cycle();

    // reset mid-stream after five delivered words
    do_reset();
    directed = 1'b1; lat = 2;
    en_i = 1'b1; dv_i = 1'b1; rdy_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      dval_i = $urandom;
      cycle();
      if (outs.size() >= 5) break;
    end
    dv_i = 1'b0; rdy_i = 1'b0;
    cycle();
    chk("mid_words", outs.size(), 5);
`ifdef HC_WORD_CNT_EN
    chk("mid_word_cnt", word_cnt, 64'd5);
`endif
    en_i = 1'b1;
    do_reset();
    en_i = 1'b1; dv_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      dval_i = $urandom;
      cycle();
    end
    idle_knobs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
